// File: rtl/hex_disp_if.sv
// Slot bus between the mmio_sys fabric and the seven-segment display core.
// Bus semantics: a write commits on the rising clk edge where cs && write are
// both high (there is no ready/wait-state path); rd_data is a pure
// combinational function of addr, and read/cs carry no side effects.
interface hex_disp_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/hex_disp_core.sv
// Multi-digit active-low seven-segment driver for an FPRO MMIO slot.
// Per-digit hex decode or raw segments, decimal points, blanking, blink and
// a 16-step global PWM brightness; every output bit is registered.
module hex_disp_core #(
    parameter int N_DIGITS   = 6,
    parameter int PWM_DIV    = 3125,
    parameter int BLINK_UNIT = 62
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_disp_if.slave             bus,
    output logic [8*N_DIGITS-1:0] hex
);
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BLK_W = $clog2(16 * BLINK_UNIT + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

    logic [3:0]          data_q [N_DIGITS];
    logic [7:0]          raw_q  [N_DIGITS];
    logic [N_DIGITS-1:0] dp_q;
    logic [N_DIGITS-1:0] blank_q;
    logic [N_DIGITS-1:0] blink_q;
    logic [3:0]          duty_q;
    logic [3:0]          rate_q;
    logic                raw_mode_q;

    logic [PRE_W-1:0]    pre_cnt;
    logic [3:0]          pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;

    logic                wr_en;
    logic                cfg_wr;
    logic                tick;
    logic                frame;
    logic [BLK_W-1:0]    blink_last;
    logic                unused_bus;

    assign wr_en      = bus.cs && bus.write;
    assign cfg_wr     = wr_en && (bus.addr == 5'd5);
    assign tick       = (pre_cnt == PRE_LAST);
    assign frame      = tick && (pwm_cnt == 4'hF);
    assign blink_last = BLK_W'((int'(rate_q) + 1) * BLINK_UNIT - 1);
    // read strobe and high write-data bits carry no function here
    assign unused_bus = ^{bus.read, bus.wr_data};

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Register file: bus writes; bits of unimplemented digits are simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                data_q[i] <= '0;
                raw_q[i]  <= '0;
            end
            dp_q       <= '0;
            blank_q    <= '1;
            blink_q    <= '0;
            duty_q     <= 4'hF;
            rate_q     <= '0;
            raw_mode_q <= 1'b0;
        end else if (wr_en) begin
            case (bus.addr)
                5'd0, 5'd1: begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        if ((i / 8) == int'(bus.addr[0]))
                            data_q[i] <= bus.wr_data[4*(i%8) +: 4];
                    end
                end
                5'd2: dp_q    <= bus.wr_data[N_DIGITS-1:0];
                5'd3: blank_q <= bus.wr_data[N_DIGITS-1:0];
                5'd4: blink_q <= bus.wr_data[N_DIGITS-1:0];
                5'd5: begin
                    duty_q     <= bus.wr_data[3:0];
                    rate_q     <= bus.wr_data[7:4];
                    raw_mode_q <= bus.wr_data[8];
                end
                default: begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        if (bus.addr == 5'(8 + i))
                            raw_q[i] <= bus.wr_data[7:0];
                    end
                end
            endcase
        end
    end

    // Prescaler, PWM step counter and blink timer; a CONFIG write restarts blink only.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            if (cfg_wr) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (frame) begin
                if (blink_cnt == blink_last) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Segment outputs: off-conditions first, then raw or hex decode, inverted for active-low pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex <= '1;
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (blank_q[i] || (blink_q[i] && blink_phase) || (pwm_cnt > duty_q))
                    hex[8*i +: 8] <= 8'hFF;
                else if (raw_mode_q)
                    hex[8*i +: 8] <= ~raw_q[i];
                else
                    hex[8*i +: 8] <= {~dp_q[i], ~seg_decode(data_q[i])};
            end
        end
    end

    // Read mux: purely combinational from addr, zero for unlisted addresses.
    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            5'd0, 5'd1: begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if ((i / 8) == int'(bus.addr[0]))
                        bus.rd_data[4*(i%8) +: 4] = data_q[i];
                end
            end
            5'd2: bus.rd_data[N_DIGITS-1:0] = dp_q;
            5'd3: bus.rd_data[N_DIGITS-1:0] = blank_q;
            5'd4: bus.rd_data[N_DIGITS-1:0] = blink_q;
            5'd5: bus.rd_data[8:0] = {raw_mode_q, rate_q, duty_q};
            5'd6: bus.rd_data[4:0] = {pwm_cnt, blink_phase};
            default: begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (bus.addr == 5'(8 + i))
                        bus.rd_data[7:0] = raw_q[i];
                end
            end
        endcase
    end
endmodule
